// File: rtl/encoder_83_req_if.sv
// Request/grant bundle between request sources, the encoder and its consumer.
interface encoder_83_req_if;
    logic E;
    logic I0n, I1n, I2n, I3n, I4n, I5n, I6n, I7n;
    logic ack;
    logic clr_ovf;
    logic A2, A1, A0;
    logic valid;
    logic pend_any;
    logic ovf;

    modport master (
        output E, I0n, I1n, I2n, I3n, I4n, I5n, I6n, I7n,
        output ack, clr_ovf,
        input  A2, A1, A0, valid, pend_any, ovf
    );

    modport slave (
        input  E, I0n, I1n, I2n, I3n, I4n, I5n, I6n, I7n,
        input  ack, clr_ovf,
        output A2, A1, A0, valid, pend_any, ovf
    );
endinterface

// File: rtl/encoder_83_req.sv
// Registered 8-to-3 request encoder: falling-edge capture, pending queue,
// fixed-priority grant presented one at a time with valid/ack handshake.
module encoder_83_req #(
    parameter int PRIO_HIGH = 1
) (
    input logic             clk,
    input logic             rst,
    encoder_83_req_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PRES = 1'b1;

    logic [7:0] w_in;
    logic [7:0] w_rise;
    logic [7:0] w_clr;
    logic [7:0] w_pend_nx;
    logic       w_ovf_set;
    logic [2:0] w_win;

    logic [7:0] r_prev;
    logic [7:0] r_pend;
    logic [0:0] r_state;
    logic       r_arm;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_pend_any;
    logic       r_ovf;

    function automatic logic [2:0] f_win(input logic [7:0] p);
        logic [2:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (PRIO_HIGH != 0) begin
                if (p[i]) w = 3'(i);
            end else begin
                if (p[7-i]) w = 3'(7 - i);
            end
        end
        return w;
    endfunction

    assign w_in = {bus.I7n, bus.I6n, bus.I5n, bus.I4n,
                   bus.I3n, bus.I2n, bus.I1n, bus.I0n};

    // r_arm is low for the first edge after reset so lines held low
    // across reset release do not look like a fresh falling edge.
    always_comb begin
        w_rise    = r_arm ? (r_prev & ~w_in) : 8'h00;
        w_clr     = 8'h00;
        if (r_state == S_PRES && bus.ack)
            w_clr = 8'h01 << r_code;
        w_pend_nx = (r_pend & ~w_clr) | w_rise;
        w_ovf_set = |(w_rise & r_pend & ~w_clr);
        w_win     = f_win(r_pend);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= 8'hFF;
            r_pend     <= 8'h00;
            r_state    <= S_IDLE;
            r_arm      <= 1'b0;
            r_code     <= 3'b000;
            r_valid    <= 1'b0;
            r_pend_any <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_prev     <= w_in;
            r_arm      <= 1'b1;
            r_pend     <= w_pend_nx;
            r_pend_any <= |w_pend_nx;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (bus.clr_ovf)
                r_ovf <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.E && (r_pend != 8'h00)) begin
                        r_state <= S_PRES;
                        r_code  <= w_win;
                        r_valid <= 1'b1;
                    end
                end
                S_PRES: begin
                    if (bus.ack) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A2       = r_code[2];
    assign bus.A1       = r_code[1];
    assign bus.A0       = r_code[0];
    assign bus.valid    = r_valid;
    assign bus.pend_any = r_pend_any;
    assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_encoder_83_req.sv
// Bench for encoder_83_req: both priority orders side by side, directed
// scenarios followed by random traffic checked against a behavioural model.
module tb_encoder_83_req;
    logic       clk;
    logic       rst;
    logic       e;
    logic       ack;
    logic       clr;
    logic [7:0] in_n;

    int tests;
    int fails;

    encoder_83_req_if if_hi ();
    encoder_83_req_if if_lo ();

    assign if_hi.E       = e;
    assign if_hi.ack     = ack;
    assign if_hi.clr_ovf = clr;
    assign {if_hi.I7n, if_hi.I6n, if_hi.I5n, if_hi.I4n,
            if_hi.I3n, if_hi.I2n, if_hi.I1n, if_hi.I0n} = in_n;
    assign if_lo.E       = e;
    assign if_lo.ack     = ack;
    assign if_lo.clr_ovf = clr;
    assign {if_lo.I7n, if_lo.I6n, if_lo.I5n, if_lo.I4n,
            if_lo.I3n, if_lo.I2n, if_lo.I1n, if_lo.I0n} = in_n;

    encoder_83_req #(.PRIO_HIGH(1)) u_hi (.clk(clk), .rst(rst), .bus(if_hi));
    encoder_83_req #(.PRIO_HIGH(0)) u_lo (.clk(clk), .rst(rst), .bus(if_lo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model, index 0 = PRIO_HIGH=1 device, index 1 = PRIO_HIGH=0
    int  m_prev [2];
    int  m_pend [2];
    bit  m_val  [2];
    int  m_code [2];
    bit  m_ovf  [2];
    bit  m_pa   [2];
    bit  m_first[2];

    function automatic int winner(int p, bit hi);
        if (hi) return $clog2(p + 1) - 1;
        return $clog2(p & -p);
    endfunction

    task automatic model_edge();
        int rise;
        int clrm;
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                m_prev[j] = 255; m_pend[j] = 0; m_val[j] = 0;
                m_code[j] = 0; m_ovf[j] = 0; m_pa[j] = 0; m_first[j] = 1;
            end else begin
                rise = m_first[j] ? 0 : (m_prev[j] & ~int'(in_n) & 255);
                m_first[j] = 0;
                clrm = (m_val[j] && ack) ? (1 << m_code[j]) : 0;
                if ((rise & m_pend[j] & ~clrm) != 0) m_ovf[j] = 1;
                else if (clr) m_ovf[j] = 0;
                if (m_val[j]) begin
                    if (ack) m_val[j] = 0;
                end else if (e && m_pend[j] != 0) begin
                    m_val[j]  = 1;
                    m_code[j] = winner(m_pend[j], (j == 0));
                end
                m_pend[j] = (m_pend[j] & ~clrm) | rise;
                m_pa[j]   = (m_pend[j] != 0);
                m_prev[j] = int'(in_n);
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] code_of(int j);
        if (j == 0) return {5'b0, if_hi.A2, if_hi.A1, if_hi.A0};
        return {5'b0, if_lo.A2, if_lo.A1, if_lo.A0};
    endfunction

    function automatic logic [7:0] out_of(int j, int which);
        logic v, p, o;
        if (j == 0) begin v = if_hi.valid; p = if_hi.pend_any; o = if_hi.ovf; end
        else        begin v = if_lo.valid; p = if_lo.pend_any; o = if_lo.ovf; end
        case (which)
            0:       return {7'b0, v};
            1:       return {7'b0, p};
            default: return {7'b0, o};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("valid[%0d]", j), out_of(j, 0), {7'b0, m_val[j]});
            chk($sformatf("pend_any[%0d]", j), out_of(j, 1), {7'b0, m_pa[j]});
            chk($sformatf("ovf[%0d]", j), out_of(j, 2), {7'b0, m_ovf[j]});
            chk($sformatf("code[%0d]", j), code_of(j), 8'(m_code[j]));
        end
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int          q_hi[$];
    int          q_lo[$];
    int          t_hi[$];
    logic [7:0]  dec;
    logic [7:0]  one;
    logic [31:0] r;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; e = 1'b1; ack = 1'b0; clr = 1'b0;
        in_n = ~8'h20;
        steps(2);
        for (int j = 0; j < 2; j++) begin
            chk("rst_valid", out_of(j, 0), 8'h00);
            chk("rst_code", code_of(j), 8'h00);
            chk("rst_pend_any", out_of(j, 1), 8'h00);
            chk("rst_ovf", out_of(j, 2), 8'h00);
        end

        // Line low across reset release must not request
        rst = 1'b0;
        steps(3);
        chk("held_low_no_req", out_of(0, 0), 8'h00);
        in_n = 8'hFF; step();
        in_n = ~8'h20; steps(2);
        for (int j = 0; j < 2; j++) begin
            chk("i5_valid", out_of(j, 0), 8'h01);
            chk("i5_code", code_of(j), 8'h05);
        end
        ack = 1'b1; step(); ack = 1'b0;
        chk("i5_ack_valid", out_of(0, 0), 8'h00);
        chk("i5_ack_pend_any", out_of(0, 1), 8'h00);
        in_n = 8'hFF; steps(2);

        // Two simultaneous requests drained with ack tied high
        ack = 1'b1;
        in_n = ~8'h44;
        for (int c = 0; c < 8; c++) begin
            step();
            if (if_hi.valid) begin q_hi.push_back(int'(code_of(0))); t_hi.push_back(c); end
            if (if_lo.valid) q_lo.push_back(int'(code_of(1)));
        end
        chk("pair_hi_count", 8'(q_hi.size()), 8'd2);
        chk("pair_lo_count", 8'(q_lo.size()), 8'd2);
        if (q_hi.size() == 2) begin
            chk("pair_hi_first", 8'(q_hi[0]), 8'd6);
            chk("pair_hi_second", 8'(q_hi[1]), 8'd2);
            chk("pair_hi_gap", 8'(t_hi[1] - t_hi[0]), 8'd2);
        end
        if (q_lo.size() == 2) begin
            chk("pair_lo_first", 8'(q_lo[0]), 8'd2);
            chk("pair_lo_second", 8'(q_lo[1]), 8'd6);
        end
        ack = 1'b0; in_n = 8'hFF; steps(2);

        // Repeat request while presented raises ovf
        in_n = ~8'h08; steps(2);
        chk("ovf_code", code_of(0), 8'h03);
        in_n = 8'hFF; step(); in_n = ~8'h08; step();
        in_n = 8'hFF; step(); in_n = ~8'h08; step();
        chk("ovf_set", out_of(0, 2), 8'h01);
        chk("ovf_pend_any", out_of(1, 1), 8'h01);
        ack = 1'b1; step(); ack = 1'b0;
        in_n = 8'hFF; step(); in_n = ~8'h08; steps(3);
        chk("ovf_regrant_code", code_of(1), 8'h03);
        ack = 1'b1; step(); ack = 1'b0;
        clr = 1'b1; step(); clr = 1'b0;
        chk("ovf_clear", out_of(0, 2), 8'h00);
        in_n = 8'hFF; steps(2);

        // Grant enable held low blocks grants but not capture
        e = 1'b0; in_n = ~8'h80; steps(5);
        chk("e0_valid", out_of(0, 0), 8'h00);
        chk("e0_pend_any", out_of(0, 1), 8'h01);
        e = 1'b1; step();
        for (int j = 0; j < 2; j++) begin
            chk("e1_valid", out_of(j, 0), 8'h01);
            chk("e1_code", code_of(j), 8'h07);
        end
        ack = 1'b1; step(); ack = 1'b0; in_n = 8'hFF; steps(2);

        // Loopback through a 3-8 decoder
        for (int k = 0; k < 8; k++) begin
            one = 8'h01 << k;
            in_n = ~one; steps(2);
            for (int j = 0; j < 2; j++) begin
                dec = ~(8'h01 << code_of(j)[2:0]);
                chk($sformatf("loop_k%0d_d%0d", k, j), dec, ~one);
            end
            ack = 1'b1; step(); ack = 1'b0; in_n = 8'hFF; step();
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            r    = $urandom;
            in_n = in_n ^ (r[7:0] & r[15:8]);
            e    = (r[17:16] != 2'b00);
            ack  = r[18];
            clr  = (r[21:19] == 3'b000);
            rst  = (r[27:22] == 6'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
